// File: rtl/fifo_burst_feeder.sv
// Burst source for the write side of the 8-entry clock-crossing FIFO: arithmetic word sequence with full/empty flow control.
// Define FEEDER_CHECKSUM_EN to append a modulo-2^WIDTH checksum word after each non-empty burst.
module fifo_burst_feeder #(
   parameter int          WIDTH = 16,
   parameter int          LEN_W = 8,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk_1,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [LEN_W-1:0] len,
   input  logic             buffer_full,
   input  logic             buffer_empty,
   output logic [WIDTH-1:0] data_1,
   output logic             data_1_en,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] sent_cnt
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SEND       = 3'd1,
      WAIT_EMPTY = 3'd2,
`ifdef FEEDER_CHECKSUM_EN
      CKSUM      = 3'd3,
`endif
      DONE       = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_1_q, data_1_d;
   logic [LEN_W-1:0] sent_cnt_q, sent_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] sent_nxt;
   logic             write_slot;
`ifdef FEEDER_CHECKSUM_EN
   logic [WIDTH-1:0] acc_q, acc_d;
   state_t           ret_q, ret_d;
`endif

   // NOTE: every always_comb target gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      data_1_d   = data_1_q;
      sent_cnt_d = sent_cnt_q;
      len_d      = len_q;
      sent_nxt   = sent_cnt_q + LEN_W'(1);
`ifdef FEEDER_CHECKSUM_EN
      acc_d      = acc_q;
      ret_d      = ret_q;
      write_slot = (state_q == SEND) || (state_q == CKSUM);
`else
      write_slot = (state_q == SEND);
`endif
      data_1_en  = write_slot && !buffer_full;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d      = len;
               sent_cnt_d = '0;
`ifdef FEEDER_CHECKSUM_EN
               acc_d      = '0;
`endif
               if (len != '0) begin
                  data_1_d = base;
                  state_d  = SEND;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         SEND: begin
            if (buffer_full) begin
               state_d = WAIT_EMPTY;
`ifdef FEEDER_CHECKSUM_EN
               ret_d   = SEND;
`endif
            end else begin
               sent_cnt_d = sent_nxt;
               data_1_d   = data_1_q + WIDTH'(STEP);
`ifdef FEEDER_CHECKSUM_EN
               acc_d      = acc_q + data_1_q;
               if (sent_nxt == len_q) begin
                  // Present the final sum directly so the checksum write can follow without a gap.
                  data_1_d = acc_q + data_1_q;
                  state_d  = CKSUM;
               end
`else
               if (sent_nxt == len_q) state_d = DONE;
`endif
            end
         end
         WAIT_EMPTY: begin
`ifdef FEEDER_CHECKSUM_EN
            if (buffer_empty) state_d = ret_q;
`else
            if (buffer_empty) state_d = SEND;
`endif
         end
`ifdef FEEDER_CHECKSUM_EN
         CKSUM: begin
            if (buffer_full) begin
               state_d = WAIT_EMPTY;
               ret_d   = CKSUM;
            end else begin
               state_d = DONE;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         data_1_q   <= '0;
         sent_cnt_q <= '0;
         len_q      <= '0;
`ifdef FEEDER_CHECKSUM_EN
         acc_q      <= '0;
         ret_q      <= SEND;
`endif
      end else begin
         state_q    <= state_d;
         data_1_q   <= data_1_d;
         sent_cnt_q <= sent_cnt_d;
         len_q      <= len_d;
`ifdef FEEDER_CHECKSUM_EN
         acc_q      <= acc_d;
         ret_q      <= ret_d;
`endif
      end
   end

   assign data_1   = data_1_q;
   assign sent_cnt = sent_cnt_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_fifo_burst_feeder.sv
// Self-checking bench for fifo_burst_feeder: the bench plays the FIFO and compares written words with a list model.
`timescale 1ns/1ps
module tb_fifo_burst_feeder;

   logic        clk_1 = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base = '0;
   logic [7:0]  len = '0;
   logic        buffer_full = 1'b0;
   logic        buffer_empty = 1'b0;
   logic [15:0] data_1;
   logic        data_1_en;
   logic        busy;
   logic        done;
   logic [7:0]  sent_cnt;

   int checks = 0;
   int failures = 0;

   fifo_burst_feeder dut (
      .clk_1(clk_1), .rst(rst), .start(start), .base(base), .len(len),
      .buffer_full(buffer_full), .buffer_empty(buffer_empty),
      .data_1(data_1), .data_1_en(data_1_en), .busy(busy), .done(done),
      .sent_cnt(sent_cnt)
   );

   always #5 clk_1 = ~clk_1;

   // Runs one burst from posedge+1 alignment; cap=0 means the FIFO never fills, mid_at<0 means no stray start.
   task automatic run_burst(input logic [15:0] b, input logic [7:0] l, input int cap,
                            input int mid_at, input string name);
      logic [15:0] exp_q[$];
      logic [15:0] got_q[$];
      logic [15:0] sum = '0;
      int fifo_cnt = 0;
      int drain = 0;
      int done_cyc = -1;
      int first_cyc = -1;
      bit busy_bad = 0;
      for (int i = 0; i < l; i++) begin
         exp_q.push_back(16'(b + i));
         sum = sum + 16'(b + i);
      end
`ifdef FEEDER_CHECKSUM_EN
      if (l != 0) exp_q.push_back(sum);
`endif
      buffer_full = 1'b0;
      buffer_empty = 1'b0;
      base = b;
      len = l;
      start = 1'b1;
      @(posedge clk_1); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
         @(negedge clk_1);
         if (busy !== 1'b1) busy_bad = 1;
         if (data_1_en === 1'b1) begin
            got_q.push_back(data_1);
            fifo_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
         end
         if (buffer_empty && data_1_en === 1'b0) fifo_cnt = 0;
         if (done === 1'b1) done_cyc = cyc;
         @(posedge clk_1); #1;
         if (cyc == mid_at) begin
            start = 1'b1;
            base = 16'hAAAA;
            len = 8'(1 + $urandom_range(0, 50));
         end else if (cyc == mid_at + 1) begin
            start = 1'b0;
         end
         buffer_empty = 1'b0;
         if (cap > 0 && fifo_cnt >= cap && !buffer_full) begin
            buffer_full = 1'b1;
            drain = $urandom_range(1, 4);
         end else if (buffer_full) begin
            if (drain > 0) drain--;
            else begin
               buffer_full = 1'b0;
               buffer_empty = 1'b1;
            end
         end
      end
      start = 1'b0;

      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL %s done_seen: got none within budget, expected one pulse", name);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s write_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s word[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (busy_bad) begin
         failures++;
         $display("FAIL %s busy_during_burst: got 0 at least once, expected 1", name);
      end
      if (cap == 0) begin
         checks++;
         if (done_cyc != exp_q.size()) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d, expected %0d", name, done_cyc, exp_q.size());
         end
         checks++;
         if (first_cyc != (l != 0 ? 0 : -1)) begin
            failures++;
            $display("FAIL %s first_write_cycle: got %0d, expected %0d", name, first_cyc, (l != 0 ? 0 : -1));
         end
      end
      @(negedge clk_1);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s after_done: got done=%b busy=%b, expected 0 0", name, done, busy);
      end
      if (l != 0) begin
         checks++;
         if (sent_cnt !== l) begin
            failures++;
            $display("FAIL %s sent_cnt: got %0d, expected %0d", name, sent_cnt, l);
         end
      end
      @(posedge clk_1); #1;
   endtask

   task automatic check_idle_zero(input string name);
      checks++;
      if ({data_1, data_1_en, busy, done, sent_cnt} !== '0) begin
         failures++;
         $display("FAIL %s outputs: got data_1=%h en=%b busy=%b done=%b sent_cnt=%0d, expected all 0",
                  name, data_1, data_1_en, busy, done, sent_cnt);
      end
   endtask

   task automatic test_reset();
      #3;
      check_idle_zero("reset");
      @(negedge clk_1);
      rst = 1'b1;
      @(posedge clk_1); #1;
   endtask

   task automatic test_basic();
      run_burst(16'h0010, 8'd3, 0, -1, "basic");
   endtask

   task automatic test_full_resume();
      run_burst(16'h0000, 8'd10, 7, -1, "full_resume");
   endtask

   task automatic test_wrap();
      run_burst(16'hFFFE, 8'd4, 0, -1, "wrap");
   endtask

   task automatic test_len_zero();
      run_burst(16'h1234, 8'd0, 0, -1, "len_zero");
   endtask

   task automatic test_reset_mid_burst();
      base = 16'h0055;
      len = 8'd5;
      start = 1'b1;
      @(posedge clk_1); #1;
      start = 1'b0;
      @(posedge clk_1); #1;
      @(posedge clk_1); #2;
      rst = 1'b0;
      #1;
      check_idle_zero("reset_mid_burst");
      @(negedge clk_1);
      rst = 1'b1;
      @(posedge clk_1); #1;
      run_burst(16'h0100, 8'd2, 0, -1, "after_reset");
   endtask

   task automatic test_ignore_start();
      run_burst(16'h0200, 8'd12, 0, 3, "ignore_start");
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         run_burst(16'($urandom), 8'($urandom_range(1, 40)), int'($urandom_range(0, 8)),
                   -1, $sformatf("random%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_resume();
      test_wrap();
      test_len_zero();
      test_reset_mid_burst();
      test_ignore_start();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
